// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational read port, single write port,
// 64-bit cycle/instret counters, trap entry / mret state updates,
// trap vector computation and interrupt-pending summary.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module csr_regfile #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           csr_rd_addr,
  output logic [`MAX_BIT_POS:0] csr_rd_data,
  input  logic                  csr_out_en,
  input  logic [11:0]           csrw_addr,
  input  logic [`MAX_BIT_POS:0] csrw_data,
  input  logic                  inst_retire,
  input  logic                  trap_en,
  input  logic [31:0]           trap_cause,
  input  logic [31:0]           trap_pc,
  input  logic [31:0]           trap_val,
  input  logic                  mret_en,
  input  logic                  irq_timer,
  input  logic                  irq_ext,
  output logic [31:0]           trap_vector,
  output logic [31:0]           mepc_out,
  output logic                  irq_pending
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic        r_mie_mtie;
  logic        r_mie_meie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch;
  logic w_wr_mepc, w_wr_mcause, w_wr_mtval;
  logic w_wr_mcycle, w_wr_mcycleh, w_wr_minstret, w_wr_minstreth;
  logic [31:0] w_mstatus;
  logic [31:0] w_mie;
  logic [31:0] w_mip;
  logic [31:0] w_tvec_base;

  assign w_wr_mstatus   = csr_out_en && (csrw_addr == A_MSTATUS);
  assign w_wr_mie       = csr_out_en && (csrw_addr == A_MIE);
  assign w_wr_mtvec     = csr_out_en && (csrw_addr == A_MTVEC);
  assign w_wr_mscratch  = csr_out_en && (csrw_addr == A_MSCRATCH);
  assign w_wr_mepc      = csr_out_en && (csrw_addr == A_MEPC);
  assign w_wr_mcause    = csr_out_en && (csrw_addr == A_MCAUSE);
  assign w_wr_mtval     = csr_out_en && (csrw_addr == A_MTVAL);
  assign w_wr_mcycle    = csr_out_en && (csrw_addr == A_MCYCLE);
  assign w_wr_mcycleh   = csr_out_en && (csrw_addr == A_MCYCLEH);
  assign w_wr_minstret  = csr_out_en && (csrw_addr == A_MINSTRET);
  assign w_wr_minstreth = csr_out_en && (csrw_addr == A_MINSTRETH);

  // mstatus and trap-state CSRs: trap beats mret beats a CSR write
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mepc         <= 32'd0;
      r_mcause       <= 32'd0;
      r_mtval        <= 32'd0;
    end else if (trap_en) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
      r_mepc         <= trap_pc & ~32'd3;
      r_mcause       <= trap_cause;
      r_mtval        <= trap_val;
    end else begin
      if (mret_en) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wr_mstatus) begin
        r_mstatus_mie  <= csrw_data[3];
        r_mstatus_mpie <= csrw_data[7];
      end
      if (w_wr_mepc)   r_mepc   <= csrw_data & ~32'd3;
      if (w_wr_mcause) r_mcause <= csrw_data;
      if (w_wr_mtval)  r_mtval  <= csrw_data;
    end
  end

  // CSRs only ever touched by explicit writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mie_mtie <= 1'b0;
      r_mie_meie <= 1'b0;
      r_mtvec    <= MTVEC_RESET & ~32'd2;
      r_mscratch <= 32'd0;
    end else begin
      if (w_wr_mie) begin
        r_mie_mtie <= csrw_data[7];
        r_mie_meie <= csrw_data[11];
      end
      if (w_wr_mtvec)    r_mtvec    <= csrw_data & ~32'd2;
      if (w_wr_mscratch) r_mscratch <= csrw_data;
    end
  end

  // free-running counters; a write to either half replaces it and skips the increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      if (w_wr_mcycle)       r_mcycle[31:0]  <= csrw_data;
      else if (w_wr_mcycleh) r_mcycle[63:32] <= csrw_data;
      else                   r_mcycle        <= r_mcycle + 64'd1;

      if (w_wr_minstret)       r_minstret[31:0]  <= csrw_data;
      else if (w_wr_minstreth) r_minstret[63:32] <= csrw_data;
      else if (inst_retire)    r_minstret        <= r_minstret + 64'd1;
    end
  end

  // assemble architectural views of the sparse status/enable/pending registers
  always_comb begin
    w_mstatus        = 32'd0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_mstatus_mpie;
    w_mstatus[3]     = r_mstatus_mie;
    w_mie            = 32'd0;
    w_mie[7]         = r_mie_mtie;
    w_mie[11]        = r_mie_meie;
    w_mip            = 32'd0;
    w_mip[7]         = irq_timer;
    w_mip[11]        = irq_ext;
  end

  // combinational read mux; unimplemented addresses read zero
  always_comb begin
    csr_rd_data = '0;
    case (csr_rd_addr)
      A_MSTATUS:              csr_rd_data = w_mstatus;
      A_MISA:                 csr_rd_data = MISA_VAL;
      A_MIE:                  csr_rd_data = w_mie;
      A_MTVEC:                csr_rd_data = r_mtvec;
      A_MSCRATCH:             csr_rd_data = r_mscratch;
      A_MEPC:                 csr_rd_data = r_mepc;
      A_MCAUSE:               csr_rd_data = r_mcause;
      A_MTVAL:                csr_rd_data = r_mtval;
      A_MIP:                  csr_rd_data = w_mip;
      A_MCYCLE, A_CYCLE:      csr_rd_data = r_mcycle[31:0];
      A_MCYCLEH, A_CYCLEH:    csr_rd_data = r_mcycle[63:32];
      A_MINSTRET, A_INSTRET:  csr_rd_data = r_minstret[31:0];
      A_MINSTRETH, A_INSTRETH: csr_rd_data = r_minstret[63:32];
      A_MHARTID:              csr_rd_data = HART_ID;
      default:                csr_rd_data = '0;
    endcase
  end

  assign w_tvec_base = {r_mtvec[31:2], 2'b00};
  // vectored mode offsets only interrupts, by cause number
  assign trap_vector = (r_mtvec[0] && trap_cause[31])
                     ? w_tvec_base + {24'd0, trap_cause[5:0], 2'b00}
                     : w_tvec_base;
  assign mepc_out    = r_mepc;
  assign irq_pending = r_mstatus_mie && (|(w_mie & w_mip));

endmodule
